// File: rtl/axi_rf_gain_pkg.sv
// Shared constants for the AXI-Lite controlled RF gain block: register map,
// reset values, response codes and default sample geometry.
package axi_rf_gain_pkg;

  localparam logic [3:0]  OFFS_GAIN   = 4'h0;
  localparam logic [3:0]  OFFS_CTRL   = 4'h4;
  localparam logic [3:0]  OFFS_SATCNT = 4'h8;
  localparam logic [3:0]  OFFS_ID     = 4'hC;

  typedef enum logic [1:0] {
    REG_GAIN   = OFFS_GAIN[3:2],
    REG_CTRL   = OFFS_CTRL[3:2],
    REG_SATCNT = OFFS_SATCNT[3:2],
    REG_ID     = OFFS_ID[3:2]
  } reg_sel_e;

  localparam logic [31:0] BLOCK_ID       = 32'h5246_4742;
  localparam logic [31:0] GAIN_RESET     = 32'h0001_0000;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam int          GAIN_FRAC_BITS = 16;
  localparam int          C_SAMPLE_WIDTH = 16;
  localparam int          C_NUM_SAMPLES  = 16;

endpackage

// File: rtl/axi_rf_gain_lane.sv
// One sample lane: stage 1 registers the signed product with the Q16.16 gain,
// stage 2 rounds half toward +inf, shifts back to sample scale and saturates.
module rf_gain_lane
  import axi_rf_gain_pkg::*;
#(
  parameter int SAMPLE_WIDTH = C_SAMPLE_WIDTH,
  parameter int GAIN_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    bypass,
  input  logic [GAIN_WIDTH-1:0]   gain,
  input  logic [SAMPLE_WIDTH-1:0] x,
  output logic [SAMPLE_WIDTH-1:0] y,
  output logic                    sat
);

  localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH;
  localparam logic signed [PW-1:0] SMAX = PW'((2 ** (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN = PW'(-(2 ** (SAMPLE_WIDTH - 1)));

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_q;
  logic signed [PW-1:0] rnd;
  logic signed [PW-1:0] shifted;

  // Bypass is a unity gain (x scaled by 2^16), so it rounds back to x exactly
  // and can never trip the saturation flag.
  always_comb begin
    if (bypass) prod = PW'($signed(x)) <<< GAIN_FRAC_BITS;
    else        prod = PW'($signed(x)) * PW'($signed(gain));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  prod_q <= '0;
    else if (en) prod_q <= prod;
  end

  always_comb begin
    rnd     = prod_q + (PW'(1) <<< (GAIN_FRAC_BITS - 1));
    shifted = rnd >>> GAIN_FRAC_BITS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      if (shifted > SMAX) begin
        y   <= {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        sat <= 1'b1;
      end else if (shifted < SMIN) begin
        y   <= {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        sat <= 1'b1;
      end else begin
        y   <= shifted[SAMPLE_WIDTH-1:0];
        sat <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_rf_gain_block.sv
// AXI-Lite register file plus a two-stage per-lane gain pipeline on an
// AXI-Stream beat of NUM_SAMPLES signed samples, with saturation counting.
module axi_rf_gain_block
  import axi_rf_gain_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int NUM_SAMPLES          = C_NUM_SAMPLES,
  parameter int SAMPLE_WIDTH         = C_SAMPLE_WIDTH
) (
  input  logic                                axis_aclk,
  input  logic                                axis_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  input  logic [NUM_SAMPLES*SAMPLE_WIDTH-1:0] rf_in_tdata,
  input  logic                                rf_in_tvalid,
  output logic                                rf_in_tready,
  output logic [NUM_SAMPLES*SAMPLE_WIDTH-1:0] rf_out_tdata,
  output logic                                rf_out_tvalid,
  input  logic                                rf_out_tready
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;

  logic [DW-1:0]          gain_reg;
  logic                   ctrl_bypass;
  logic [31:0]            satcnt;
  logic                   aw_rdy;
  logic                   wr_fire;
  logic                   rd_fire;
  reg_sel_e               wr_sel;
  reg_sel_e               rd_sel;
  logic [DW-1:0]          rd_mux;
  logic                   rst_done;
  logic                   en;
  logic                   in_fire;
  logic                   out_fire;
  logic                   v1;
  logic                   v2;
  logic [NUM_SAMPLES-1:0] lane_sat;
  logic [31:0]            nsat;
  logic [32:0]            sat_sum;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{s00_axi_awaddr, s00_axi_araddr};

  assign wr_sel  = reg_sel_e'(s00_axi_awaddr[3:2]);
  assign rd_sel  = reg_sel_e'(s00_axi_araddr[3:2]);
  assign wr_fire = aw_rdy && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_fire = s00_axi_arready && s00_axi_arvalid;

  assign s00_axi_awready = aw_rdy;
  assign s00_axi_wready  = aw_rdy;

  // Write address/data channels: single ready pulse, one response outstanding.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      aw_rdy         <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= '0;
    end else begin
      aw_rdy <= !aw_rdy && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
      if (wr_fire) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= RESP_OKAY;
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      gain_reg    <= DW'(GAIN_RESET);
      ctrl_bypass <= 1'b0;
    end else if (wr_fire) begin
      if (wr_sel == REG_GAIN) begin
        for (int unsigned b = 0; b < DW / 8; b++)
          if (s00_axi_wstrb[b]) gain_reg[b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
      end
      if (wr_sel == REG_CTRL && s00_axi_wstrb[0]) ctrl_bypass <= s00_axi_wdata[0];
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (rd_sel)
      REG_GAIN:   rd_mux = gain_reg;
      REG_CTRL:   rd_mux[0] = ctrl_bypass;
      REG_SATCNT: rd_mux = DW'(satcnt);
      REG_ID:     rd_mux = DW'(BLOCK_ID);
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= '0;
    end else begin
      s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
      if (rd_fire) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
        s00_axi_rresp  <= RESP_OKAY;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  // rst_done keeps rf_in_tready low through reset and lets it rise the first
  // cycle after release, while en itself stays purely combinational.
  assign en            = !v2 || rf_out_tready;
  assign rf_in_tready  = en && rst_done;
  assign in_fire       = rf_in_tvalid && rf_in_tready;
  assign rf_out_tvalid = v2;
  assign out_fire      = v2 && rf_out_tready;

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      rst_done <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (en) begin
        v1 <= in_fire;
        v2 <= v1;
      end
    end
  end

  for (genvar i = 0; i < NUM_SAMPLES; i++) begin : g_lane
    rf_gain_lane #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .GAIN_WIDTH   (DW)
    ) u_lane (
      .clk    (axis_aclk),
      .rst_n  (axis_aresetn),
      .en     (en),
      .bypass (ctrl_bypass),
      .gain   (gain_reg),
      .x      (rf_in_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .y      (rf_out_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .sat    (lane_sat[i])
    );
  end

  always_comb begin
    nsat = '0;
    for (int unsigned i = 0; i < NUM_SAMPLES; i++) nsat = nsat + 32'(lane_sat[i]);
    sat_sum = {1'b0, satcnt} + {1'b0, nsat};
  end

  // A clearing write takes priority over a same-cycle increment.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      satcnt <= '0;
    end else if (wr_fire && wr_sel == REG_SATCNT) begin
      satcnt <= '0;
    end else if (out_fire) begin
      satcnt <= sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end

endmodule

// File: tb/tb_axi_rf_gain_block.sv
// Directed self-checking bench for axi_rf_gain_block: register access,
// gain arithmetic, saturation counting, backpressure, bypass and reset.
module tb_axi_rf_gain_block;

  logic         axis_aclk = 1'b0;
  logic         axis_aresetn;
  logic [3:0]   s00_axi_awaddr;
  logic         s00_axi_awvalid;
  logic         s00_axi_awready;
  logic [31:0]  s00_axi_wdata;
  logic [3:0]   s00_axi_wstrb;
  logic         s00_axi_wvalid;
  logic         s00_axi_wready;
  logic [1:0]   s00_axi_bresp;
  logic         s00_axi_bvalid;
  logic         s00_axi_bready;
  logic [3:0]   s00_axi_araddr;
  logic         s00_axi_arvalid;
  logic         s00_axi_arready;
  logic [31:0]  s00_axi_rdata;
  logic [1:0]   s00_axi_rresp;
  logic         s00_axi_rvalid;
  logic         s00_axi_rready;
  logic [255:0] rf_in_tdata;
  logic         rf_in_tvalid;
  logic         rf_in_tready;
  logic [255:0] rf_out_tdata;
  logic         rf_out_tvalid;
  logic         rf_out_tready;

  int checks   = 0;
  int failures = 0;

  always #5 axis_aclk = ~axis_aclk;

  axi_rf_gain_block #(
    .C_S00_AXI_DATA_WIDTH (32),
    .C_S00_AXI_ADDR_WIDTH (4),
    .NUM_SAMPLES          (16),
    .SAMPLE_WIDTH         (16)
  ) dut (
    .axis_aclk       (axis_aclk),
    .axis_aresetn    (axis_aresetn),
    .s00_axi_awaddr  (s00_axi_awaddr),
    .s00_axi_awvalid (s00_axi_awvalid),
    .s00_axi_awready (s00_axi_awready),
    .s00_axi_wdata   (s00_axi_wdata),
    .s00_axi_wstrb   (s00_axi_wstrb),
    .s00_axi_wvalid  (s00_axi_wvalid),
    .s00_axi_wready  (s00_axi_wready),
    .s00_axi_bresp   (s00_axi_bresp),
    .s00_axi_bvalid  (s00_axi_bvalid),
    .s00_axi_bready  (s00_axi_bready),
    .s00_axi_araddr  (s00_axi_araddr),
    .s00_axi_arvalid (s00_axi_arvalid),
    .s00_axi_arready (s00_axi_arready),
    .s00_axi_rdata   (s00_axi_rdata),
    .s00_axi_rresp   (s00_axi_rresp),
    .s00_axi_rvalid  (s00_axi_rvalid),
    .s00_axi_rready  (s00_axi_rready),
    .rf_in_tdata     (rf_in_tdata),
    .rf_in_tvalid    (rf_in_tvalid),
    .rf_in_tready    (rf_in_tready),
    .rf_out_tdata    (rf_out_tdata),
    .rf_out_tvalid   (rf_out_tvalid),
    .rf_out_tready   (rf_out_tready)
  );

  function automatic logic [255:0] vec5(input logic [15:0] a, b, c, d, e);
    logic [255:0] v;
    v = '0;
    v[15:0]  = a;
    v[31:16] = b;
    v[47:32] = c;
    v[63:48] = d;
    v[79:64] = e;
    return v;
  endfunction

  function automatic logic [255:0] beat_k(input int i);
    logic [255:0] v;
    for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'(i * 256 + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    s00_axi_awaddr = a; s00_axi_wdata = d; s00_axi_wstrb = s;
    s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1; s00_axi_bready = 1'b0;
    n = 0;
    while (!s00_axi_awready && n < 20) begin tick(); n++; end
    tick();
    s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
    n = 0;
    while (!s00_axi_bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (s00_axi_bvalid !== 1'b1 || s00_axi_bresp !== 2'b00) begin
      failures++;
      $display("FAIL write_resp addr=%h bvalid=%b bresp=%h required bvalid=1 bresp=0", a, s00_axi_bvalid, s00_axi_bresp);
    end
    s00_axi_bready = 1'b1;
    tick();
    s00_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    s00_axi_araddr = a; s00_axi_arvalid = 1'b1; s00_axi_rready = 1'b0;
    n = 0;
    while (!s00_axi_arready && n < 20) begin tick(); n++; end
    tick();
    s00_axi_arvalid = 1'b0;
    n = 0;
    while (!s00_axi_rvalid && n < 20) begin tick(); n++; end
    d = s00_axi_rdata;
    checks++;
    if (s00_axi_rvalid !== 1'b1 || s00_axi_rresp !== 2'b00) begin
      failures++;
      $display("FAIL read_resp addr=%h rvalid=%b rresp=%h required rvalid=1 rresp=0", a, s00_axi_rvalid, s00_axi_rresp);
    end
    s00_axi_rready = 1'b1;
    tick();
    s00_axi_rready = 1'b0;
  endtask

  task automatic stream_one(input logic [255:0] din, output logic [255:0] dout, output int lat);
    int n;
    rf_out_tready = 1'b1; rf_in_tvalid = 1'b1; rf_in_tdata = din;
    n = 0;
    while (!rf_in_tready && n < 10) begin tick(); n++; end
    tick();
    rf_in_tvalid = 1'b0;
    lat = 1;
    while (!rf_out_tvalid && lat < 10) begin tick(); lat++; end
    dout = rf_out_tdata;
    tick();
  endtask

  task automatic do_reset();
    axis_aresetn = 1'b0;
    s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; s00_axi_bready = 1'b0;
    s00_axi_arvalid = 1'b0; s00_axi_rready = 1'b0;
    s00_axi_awaddr = '0; s00_axi_araddr = '0; s00_axi_wdata = '0; s00_axi_wstrb = '0;
    rf_in_tvalid = 1'b0; rf_in_tdata = '0; rf_out_tready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [5:0] hs;
    do_reset();
    hs = {s00_axi_awready, s00_axi_wready, s00_axi_bvalid, s00_axi_arready, s00_axi_rvalid, rf_out_tvalid};
    checks++;
    if (hs !== 6'b0 || rf_in_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshakes got=%b in_tready=%b required 000000/0", hs, rf_in_tready);
    end
    checks++;
    if (rf_out_tdata !== '0 || s00_axi_rdata !== '0 || s00_axi_bresp !== 2'b0 || s00_axi_rresp !== 2'b0) begin
      failures++;
      $display("FAIL reset_data tdata=%h rdata=%h bresp=%h rresp=%h required all zero", rf_out_tdata, s00_axi_rdata, s00_axi_bresp, s00_axi_rresp);
    end
    axis_aresetn = 1'b1;
    tick();
    checks++;
    if (rf_in_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_tready got=%b required 1", rf_in_tready);
    end
  endtask

  task automatic test_unity();
    logic [31:0] d;
    logic [255:0] din, dout;
    int lat;
    axi_read(4'h0, d);
    checks++; if (d !== 32'h0001_0000) begin failures++; $display("FAIL gain_reset got=%h required 00010000", d); end
    axi_read(4'h4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_reset got=%h required 00000000", d); end
    axi_read(4'h8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL satcnt_reset got=%h required 00000000", d); end
    axi_read(4'hC, d);
    checks++; if (d !== 32'h5246_4742) begin failures++; $display("FAIL id got=%h required 52464742", d); end
    din = vec5(16'h0064, 16'h1000, 16'h8000, 16'h0000, 16'hFFFF);
    stream_one(din, dout, lat);
    checks++; if (dout !== din) begin failures++; $display("FAIL unity_data got=%h required %h", dout, din); end
    checks++; if (lat != 2) begin failures++; $display("FAIL unity_latency got=%0d required 2", lat); end
    checks++; if (rf_out_tvalid !== 1'b0) begin failures++; $display("FAIL unity_single_beat tvalid=%b required 0", rf_out_tvalid); end
  endtask

  task automatic test_gain();
    logic [31:0] d;
    logic [255:0] din, dout, exp;
    int lat;
    axi_write(4'h0, 32'h000A_0000, 4'hF);
    din = vec5(16'h0064, 16'h1000, 16'h8000, 16'h0000, 16'hFFFF);
    exp = vec5(16'h03E8, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFF6);
    stream_one(din, dout, lat);
    checks++; if (dout !== exp) begin failures++; $display("FAIL gain10_data got=%h required %h", dout, exp); end
    axi_read(4'h8, d);
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL satcnt_one_beat got=%0d required 2", d); end
    stream_one(din, dout, lat);
    axi_read(4'h8, d);
    checks++; if (d !== 32'd4) begin failures++; $display("FAIL satcnt_two_beats got=%0d required 4", d); end
    axi_write(4'h8, 32'h0, 4'hF);
    axi_read(4'h8, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL satcnt_clear got=%0d required 0", d); end
    axi_write(4'hC, 32'h1234_5678, 4'hF);
    axi_read(4'hC, d);
    checks++; if (d !== 32'h5246_4742) begin failures++; $display("FAIL id_write_ignored got=%h required 52464742", d); end
  endtask

  task automatic test_half_round();
    logic [255:0] din, dout, exp;
    int lat;
    axi_write(4'h0, 32'h0000_8000, 4'hF);
    din = vec5(16'h0003, 16'hFFFD, 16'h0000, 16'h0000, 16'h0000);
    exp = vec5(16'h0002, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    stream_one(din, dout, lat);
    checks++; if (dout !== exp) begin failures++; $display("FAIL half_round got=%h required %h", dout, exp); end
  endtask

  task automatic test_backpressure();
    int sent, recv, gaps, stall_seen, stall_bad, bad_data, extra;
    logic started, in_acc;
    sent = 0; recv = 0; gaps = 0; stall_seen = 0; stall_bad = 0; bad_data = 0; extra = 0;
    started = 1'b0;
    axi_write(4'h0, 32'h0001_0000, 4'hF);
    for (int c = 0; c < 60 && recv < 12; c++) begin
      rf_out_tready = !(c >= 4 && c < 9);
      rf_in_tvalid  = (sent < 12);
      rf_in_tdata   = beat_k(sent);
      #1;
      in_acc = rf_in_tvalid && rf_in_tready;
      if (!rf_out_tready && rf_out_tvalid) begin
        stall_seen++;
        if (rf_in_tready !== 1'b0) stall_bad++;
      end
      if (rf_out_tvalid && rf_out_tready) begin
        if (rf_out_tdata !== beat_k(recv)) bad_data++;
        recv++;
        started = 1'b1;
      end else if (started && rf_out_tready) begin
        gaps++;
      end
      tick();
      if (in_acc) sent++;
    end
    rf_in_tvalid = 1'b0; rf_out_tready = 1'b1;
    repeat (3) begin if (rf_out_tvalid) extra++; tick(); end
    checks++; if (recv != 12) begin failures++; $display("FAIL bp_count got=%0d required 12", recv); end
    checks++; if (bad_data != 0) begin failures++; $display("FAIL bp_data bad=%0d required 0", bad_data); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL bp_gaps got=%0d required 0", gaps); end
    checks++; if (stall_seen != 5 || stall_bad != 0) begin
      failures++; $display("FAIL bp_stall seen=%0d tready_high=%0d required 5/0", stall_seen, stall_bad);
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL bp_duplicate got=%0d required 0", extra); end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    do_reset();
    axis_aresetn = 1'b1;
    tick();
    axi_write(4'h0, 32'h00FF_0000, 4'h4);
    axi_read(4'h0, d);
    checks++; if (d !== 32'h00FF_0000) begin failures++; $display("FAIL gain_strobe got=%h required 00FF0000", d); end
    axi_write(4'h4, 32'h0000_0001, 4'h2);
    axi_read(4'h4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_strobe got=%h required 00000000", d); end
  endtask

  task automatic test_bypass_reset();
    logic [31:0] d0, d;
    logic [255:0] din, dout;
    int lat;
    axi_write(4'h0, 32'h000A_0000, 4'hF);
    axi_write(4'h4, 32'h0000_0001, 4'hF);
    axi_read(4'h4, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL ctrl_bypass_read got=%h required 00000001", d); end
    axi_read(4'h8, d0);
    din = vec5(16'h0064, 16'h1000, 16'h8000, 16'h0000, 16'hFFFF);
    stream_one(din, dout, lat);
    checks++; if (dout !== din) begin failures++; $display("FAIL bypass_data got=%h required %h", dout, din); end
    axi_read(4'h8, d);
    checks++; if (d !== d0) begin failures++; $display("FAIL bypass_satcnt got=%0d required %0d", d, d0); end
    rf_out_tready = 1'b1; rf_in_tvalid = 1'b1; rf_in_tdata = din;
    tick();
    rf_in_tvalid = 1'b0;
    tick();
    axis_aresetn = 1'b0;
    tick();
    checks++; if (rf_out_tvalid !== 1'b0 || rf_in_tready !== 1'b0 || rf_out_tdata !== '0) begin
      failures++;
      $display("FAIL midstream_reset tvalid=%b in_tready=%b tdata=%h required 0/0/0", rf_out_tvalid, rf_in_tready, rf_out_tdata);
    end
    axis_aresetn = 1'b1;
    tick();
    checks++; if (rf_out_tvalid !== 1'b0 || rf_in_tready !== 1'b1) begin
      failures++; $display("FAIL post_reset tvalid=%b in_tready=%b required 0/1", rf_out_tvalid, rf_in_tready);
    end
    axi_read(4'h0, d);
    checks++; if (d !== 32'h0001_0000) begin failures++; $display("FAIL post_reset_gain got=%h required 00010000", d); end
    axi_read(4'h4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL post_reset_ctrl got=%h required 00000000", d); end
    axi_read(4'h8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL post_reset_satcnt got=%h required 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_gain();
    test_half_round();
    test_backpressure();
    test_strobe();
    test_bypass_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
